riptide_ctrl_pipe: RTL and testbench
====================================

# riptide_ctrl_pipe

Parametrised pipeline control-word shift chain with integrated register-file RAW hazard detection for the RIPTIDE core family. It replaces the hand-written per-signal stage registers (SC1..SC7, WC1..WC7, regf_w1..5, etc.) with one configurable chain of DEPTH stages carrying an opaque CTRL_W-bit control word plus register-write tags. It sits between decode_unit and the execution datapath and supplies the stall/flush/bubble semantics the hazard unit drives.

## Interface
- CTRL_W, 32, width of opaque control word per stage
- DEPTH, 7, number of pipeline stages (stage 1 = first after decode)
- REG_AW, 3, register-file address width
- FLUSH_DEPTH, 4, stages 1..FLUSH_DEPTH cleared by flush; legal 1..DEPTH
- HAZ_LO, 1, first stage checked for RAW hazard; legal 1..HAZ_HI
- HAZ_HI, 5, last stage checked for RAW hazard; legal HAZ_LO..DEPTH
- clk  in  1  single clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- stall  in  1  freeze entire chain (data_hazard / cache miss)
- flush  in  1  clear stages 1..FLUSH_DEPTH (taken branch)
- in_valid  in  1  decoder presents an instruction
- in_ctrl  in  CTRL_W  control word of issuing instruction
- in_wren  in  1  issuing instruction writes the register file
- in_waddr  in  REG_AW  its destination register
- rd_en  in  1  issuing instruction reads the register file
- rd_addr  in  REG_AW  its source register
- hazard  out  1  RAW hazard on issuing instruction (combinational)
- stage_valid  out  DEPTH  bit k-1 = stage k holds an instruction
- stage_ctrl  out  DEPTH*CTRL_W  stage k at bits [k*CTRL_W-1 -: CTRL_W]
- stage_wren  out  DEPTH  per-stage register-write enable
- stage_waddr  out  DEPTH*REG_AW  per-stage destination, same packing
- occupancy  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- Per stage state: valid, ctrl, wren, waddr. Bubble = all four zero.
- Priority per cycle: RST > stall > flush > hazard > normal.
- RST: every stage becomes bubble.
- stall: every stage holds, including stages beyond FLUSH_DEPTH; flush and issue ignored that cycle (upstream holds flush until stall drops).
- flush (no stall): stages 1..FLUSH_DEPTH load bubble; stages FLUSH_DEPTH+1..DEPTH shift normally (stage k <= stage k-1).
- hazard (no stall/flush): stage 1 loads bubble, stages 2..DEPTH shift; decoder must re-present the same instruction.
- normal: stage 1 loads {in_valid, in_valid?in_ctrl:0, in_valid&in_wren, in_valid?in_waddr:0}; stages 2..DEPTH shift; stage DEPTH contents discarded.
- hazard = rd_en & in_valid & OR over k in HAZ_LO..HAZ_HI of (stage_valid[k] & stage_wren[k] & stage_waddr[k]==rd_addr). Asserted regardless of stall/flush; ignored internally when those win.
- occupancy = popcount(stage_valid), combinational.

## Timing
- Reset values: all stage_* outputs 0, occupancy 0, hazard 0.
- Latency: instruction accepted at edge n appears in stage k after edge n+k-1, plus one cycle per stalled cycle.
- hazard: zero-latency combinational from rd_*, in_valid and registered stage state; no path from stall/flush to hazard.
- Wrap-around: none; chain is a pure shift, stage DEPTH drops out.
- RST during stall or flush: reset wins, chain empty on next cycle.
- FLUSH_DEPTH == DEPTH: flush empties chain entirely.

## Structure
- Package riptide_pipe_pkg: default parameter constants, BUBBLE zero constant, stage-record typedef (valid, ctrl, wren, waddr) parametrised via localparams.
- One sub-module pipe_stage_reg: single stage with hold / load-bubble / load-input controls; instantiated DEPTH times by generate loop.
- Elaboration-time checks on legal parameter ranges.

## Test plan
- Reset then issue ctrl 0xA5A5_0001 with in_valid=1 for one cycle -> appears stage 1 after 1 edge, stage 7 after 7 edges, occupancy 1 throughout, 0 after 8th edge.
- Issue wren=1 waddr=3, next cycle rd_en=1 rd_addr=3 -> hazard=1 for 5 cycles (stages 1..5), stage 1 bubble each cycle, hazard=0 once write reaches stage 6.
- Fill 7 stages with valid ops, assert flush one cycle -> stages 1..4 bubble, stages 5..7 = old stages 4..6, occupancy 3.
- Assert stall 3 cycles with flush and in_valid=1 -> all stage outputs unchanged; after release flush acts on the following cycle.
- Assert RST during stall with full chain -> all outputs 0 next cycle, hazard 0.
- Parameter sweep DEPTH=4, CTRL_W=8, FLUSH_DEPTH=4, HAZ_LO=2, HAZ_HI=3 -> flush empties chain; write in stage 1 does not raise hazard, stage 2/3 does.

Source files
------------

// File: rtl/riptide_pipe_pkg.sv
// Shared constants and record types for the RIPTIDE pipeline control-word chain.
package riptide_pipe_pkg;

   localparam int CTRL_W_DEF      = 32;
   localparam int DEPTH_DEF       = 7;
   localparam int REG_AW_DEF      = 3;
   localparam int FLUSH_DEPTH_DEF = 4;
   localparam int HAZ_LO_DEF      = 1;
   localparam int HAZ_HI_DEF      = 5;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_BUBBLE = 2'd2
   } stage_op_e;

   typedef struct packed {
      logic                  valid;
      logic [CTRL_W_DEF-1:0] ctrl;
      logic                  wren;
      logic [REG_AW_DEF-1:0] waddr;
   } stage_rec_t;

   localparam stage_rec_t BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: holds, loads a bubble, or loads its upstream neighbour.
module pipe_stage_reg
   import riptide_pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              i_hold,
   input  logic              i_bubble,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic              i_wren,
   input  logic [REG_AW-1:0] i_waddr,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic              o_wren,
   output logic [REG_AW-1:0] o_waddr
);

   stage_op_e         w_op;
   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_wren;
   logic [REG_AW-1:0] r_waddr;

   // Hold outranks bubble so a stall freezes even the stages a flush would clear.
   always_comb begin
      w_op = ST_LOAD;
      if (i_hold)
         w_op = ST_HOLD;
      else if (i_bubble)
         w_op = ST_BUBBLE;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_wren  <= 1'b0;
         r_waddr <= '0;
      end else begin
         case (w_op)
            ST_LOAD: begin
               r_valid <= i_valid;
               r_ctrl  <= i_ctrl;
               r_wren  <= i_wren;
               r_waddr <= i_waddr;
            end
            ST_BUBBLE: begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
               r_wren  <= 1'b0;
               r_waddr <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_wren  = r_wren;
   assign o_waddr = r_waddr;

endmodule

// File: rtl/riptide_ctrl_pipe.sv
// Configurable control-word shift chain with stall/flush/bubble handling and
// RAW hazard detection against in-flight register writes.
module riptide_ctrl_pipe
   import riptide_pipe_pkg::*;
#(
   parameter int CTRL_W      = CTRL_W_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int REG_AW      = REG_AW_DEF,
   parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
   parameter int HAZ_LO      = HAZ_LO_DEF,
   parameter int HAZ_HI      = HAZ_HI_DEF
) (
   input  logic                         clk,
   input  logic                         RST,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic                         in_wren,
   input  logic [REG_AW-1:0]            in_waddr,
   input  logic                         rd_en,
   input  logic [REG_AW-1:0]            rd_addr,
   output logic                         hazard,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [DEPTH*CTRL_W-1:0]      stage_ctrl,
   output logic [DEPTH-1:0]             stage_wren,
   output logic [DEPTH*REG_AW-1:0]      stage_waddr,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   if (DEPTH < 1) begin : g_bad_depth
      $error("riptide_ctrl_pipe: DEPTH must be at least 1");
   end
   if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > DEPTH) begin : g_bad_flush
      $error("riptide_ctrl_pipe: FLUSH_DEPTH must be in 1..DEPTH");
   end
   if (HAZ_LO < 1 || HAZ_LO > HAZ_HI || HAZ_HI > DEPTH) begin : g_bad_haz
      $error("riptide_ctrl_pipe: need 1 <= HAZ_LO <= HAZ_HI <= DEPTH");
   end

   logic [DEPTH-1:0]        w_d_valid;
   logic [DEPTH*CTRL_W-1:0] w_d_ctrl;
   logic [DEPTH-1:0]        w_d_wren;
   logic [DEPTH*REG_AW-1:0] w_d_waddr;
   logic [DEPTH-1:0]        w_bubble;
   logic                    w_match;
   logic [OCC_W-1:0]        w_occ;

   // Fields of an invalid issue slot are forced to zero so stage 1 gets a clean bubble.
   assign w_d_valid[0]          = in_valid;
   assign w_d_ctrl[CTRL_W-1:0]  = in_valid ? in_ctrl : '0;
   assign w_d_wren[0]           = in_valid & in_wren;
   assign w_d_waddr[REG_AW-1:0] = in_valid ? in_waddr : '0;

   for (genvar i = 1; i < DEPTH; i++) begin : g_link
      assign w_d_valid[i]                = stage_valid[i-1];
      assign w_d_ctrl[i*CTRL_W +: CTRL_W] = stage_ctrl[(i-1)*CTRL_W +: CTRL_W];
      assign w_d_wren[i]                 = stage_wren[i-1];
      assign w_d_waddr[i*REG_AW +: REG_AW] = stage_waddr[(i-1)*REG_AW +: REG_AW];
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      assign w_bubble[i] = ((i < FLUSH_DEPTH) && flush) || ((i == 0) && hazard);

      pipe_stage_reg #(
         .CTRL_W (CTRL_W),
         .REG_AW (REG_AW)
      ) u_stage (
         .clk      (clk),
         .RST      (RST),
         .i_hold   (stall),
         .i_bubble (w_bubble[i]),
         .i_valid  (w_d_valid[i]),
         .i_ctrl   (w_d_ctrl[i*CTRL_W +: CTRL_W]),
         .i_wren   (w_d_wren[i]),
         .i_waddr  (w_d_waddr[i*REG_AW +: REG_AW]),
         .o_valid  (stage_valid[i]),
         .o_ctrl   (stage_ctrl[i*CTRL_W +: CTRL_W]),
         .o_wren   (stage_wren[i]),
         .o_waddr  (stage_waddr[i*REG_AW +: REG_AW])
      );
   end

   // Hazard depends only on issue-side inputs and registered state, never on stall/flush.
   always_comb begin
      w_match = 1'b0;
      for (int k = HAZ_LO; k <= HAZ_HI; k++) begin
         if (stage_valid[k-1] && stage_wren[k-1] &&
             (stage_waddr[(k-1)*REG_AW +: REG_AW] == rd_addr))
            w_match = 1'b1;
      end
   end

   assign hazard = rd_en & in_valid & w_match;

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++)
         w_occ = w_occ + OCC_W'(stage_valid[i]);
   end

   assign occupancy = w_occ;

endmodule

// File: tb/tb_riptide_ctrl_pipe.sv
// Bench for riptide_ctrl_pipe: hazard vector table, hand-written corner sequences,
// a scoreboard on the chain output, and a reduced-depth parameter instance.
module tb_riptide_ctrl_pipe;

   logic         clk = 1'b0;
   logic         RST, stall, flush, in_valid, in_wren, rd_en;
   logic [31:0]  in_ctrl;
   logic [2:0]   in_waddr, rd_addr;
   logic         hazard;
   logic [6:0]   stage_valid, stage_wren;
   logic [223:0] stage_ctrl;
   logic [20:0]  stage_waddr;
   logic [2:0]   occupancy;

   logic         b_rst, b_stall, b_flush, b_in_valid, b_in_wren, b_rd_en;
   logic [7:0]   b_in_ctrl;
   logic [2:0]   b_in_waddr, b_rd_addr;
   logic         b_hazard;
   logic [3:0]   b_stage_valid, b_stage_wren;
   logic [31:0]  b_stage_ctrl;
   logic [11:0]  b_stage_waddr;
   logic [2:0]   b_occupancy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riptide_ctrl_pipe dut (
      .clk(clk), .RST(RST), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wren(in_wren), .in_waddr(in_waddr),
      .rd_en(rd_en), .rd_addr(rd_addr), .hazard(hazard),
      .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .stage_wren(stage_wren),
      .stage_waddr(stage_waddr), .occupancy(occupancy)
   );

   riptide_ctrl_pipe #(
      .CTRL_W(8), .DEPTH(4), .REG_AW(3), .FLUSH_DEPTH(4), .HAZ_LO(2), .HAZ_HI(3)
   ) dut_small (
      .clk(clk), .RST(b_rst), .stall(b_stall), .flush(b_flush),
      .in_valid(b_in_valid), .in_ctrl(b_in_ctrl), .in_wren(b_in_wren), .in_waddr(b_in_waddr),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .hazard(b_hazard),
      .stage_valid(b_stage_valid), .stage_ctrl(b_stage_ctrl), .stage_wren(b_stage_wren),
      .stage_waddr(b_stage_waddr), .occupancy(b_occupancy)
   );

   typedef struct {
      logic       w_wren;
      logic [2:0] w_addr;
      int         pos;
      logic       r_en;
      logic [2:0] r_addr;
      logic       r_valid;
      logic       exp_haz;
   } hz_vec_t;

   typedef struct packed {
      logic        v;
      logic [31:0] c;
      logic        w;
      logic [2:0]  a;
   } rec_t;

   hz_vec_t hv[10];
   rec_t    sb_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] sc(input int k);
      return stage_ctrl[k*32-1 -: 32];
   endfunction

   task automatic idle();
      stall = 0; flush = 0; in_valid = 0; in_ctrl = 0; in_wren = 0;
      in_waddr = 0; rd_en = 0; rd_addr = 0;
   endtask

   task automatic do_reset();
      idle();
      RST = 1;
      tick();
      RST = 0;
   endtask

   task automatic drive(input logic v, input logic [31:0] c, input logic w, input logic [2:0] a);
      in_valid = v; in_ctrl = c; in_wren = w; in_waddr = a;
   endtask

   task automatic fill7();
      for (int j = 1; j <= 7; j++) begin
         drive(1'b1, 32'h100 + j, 1'b1, 3'(j));
         tick();
      end
      idle();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_small [4];
      rec_t exp_r, act_r;

      hv[0] = '{1'b1, 3'd3, 1, 1'b1, 3'd3, 1'b1, 1'b1};
      hv[1] = '{1'b1, 3'd3, 5, 1'b1, 3'd3, 1'b1, 1'b1};
      hv[2] = '{1'b1, 3'd3, 6, 1'b1, 3'd3, 1'b1, 1'b0};
      hv[3] = '{1'b1, 3'd3, 7, 1'b1, 3'd3, 1'b1, 1'b0};
      hv[4] = '{1'b1, 3'd3, 2, 1'b0, 3'd3, 1'b1, 1'b0};
      hv[5] = '{1'b1, 3'd3, 2, 1'b1, 3'd4, 1'b1, 1'b0};
      hv[6] = '{1'b1, 3'd3, 2, 1'b1, 3'd3, 1'b0, 1'b0};
      hv[7] = '{1'b0, 3'd3, 2, 1'b1, 3'd3, 1'b1, 1'b0};
      hv[8] = '{1'b1, 3'd0, 3, 1'b1, 3'd0, 1'b1, 1'b1};
      hv[9] = '{1'b1, 3'd7, 4, 1'b1, 3'd7, 1'b1, 1'b1};

      b_rst = 1; b_stall = 0; b_flush = 0; b_in_valid = 0; b_in_ctrl = 0;
      b_in_wren = 0; b_in_waddr = 0; b_rd_en = 0; b_rd_addr = 0;

      // Reset state
      do_reset();
      chk("rst_valid", 64'(stage_valid), 0);
      chk("rst_ctrl_nonzero", 64'(|stage_ctrl), 0);
      chk("rst_wren", 64'(stage_wren), 0);
      chk("rst_waddr", 64'(stage_waddr), 0);
      chk("rst_occ", 64'(occupancy), 0);
      chk("rst_hazard", 64'(hazard), 0);

      // Single instruction walks the chain
      drive(1'b1, 32'hA5A5_0001, 1'b0, 3'd0);
      tick();
      idle();
      for (int k = 1; k <= 7; k++) begin
         chk($sformatf("lat_valid_s%0d", k), 64'(stage_valid), 64'(7'(1) << (k-1)));
         chk($sformatf("lat_ctrl_s%0d", k), 64'(sc(k)), 64'h A5A5_0001);
         chk($sformatf("lat_occ_s%0d", k), 64'(occupancy), 1);
         tick();
      end
      chk("lat_drop_occ", 64'(occupancy), 0);
      chk("lat_drop_valid", 64'(stage_valid), 0);

      // Hazard vector table
      for (int i = 0; i < 10; i++) begin
         do_reset();
         drive(1'b1, 32'h1000 + i, hv[i].w_wren, hv[i].w_addr);
         tick();
         idle();
         repeat (hv[i].pos - 1) tick();
         chk($sformatf("hz%0d_pos", i), 64'(stage_valid), 64'(7'(1) << (hv[i].pos - 1)));
         drive(hv[i].r_valid, 32'hBEEF, 1'b0, 3'd0);
         rd_en = hv[i].r_en;
         rd_addr = hv[i].r_addr;
         #1;
         chk($sformatf("hz%0d_hazard", i), 64'(hazard), 64'(hv[i].exp_haz));
         idle();
      end

      // Hazard inserts bubbles until the write leaves stage 5
      do_reset();
      drive(1'b1, 32'h11, 1'b1, 3'd3);
      tick();
      drive(1'b1, 32'h22, 1'b0, 3'd0);
      rd_en = 1; rd_addr = 3;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("hzseq_hazard%0d", i), 64'(hazard), 1);
         tick();
         chk($sformatf("hzseq_valid%0d", i), 64'(stage_valid), 64'(7'(1) << (i+1)));
      end
      #1;
      chk("hzseq_clear", 64'(hazard), 0);
      tick();
      idle();
      chk("hzseq_issue_valid", 64'(stage_valid), 64'h41);
      chk("hzseq_issue_ctrl", 64'(sc(1)), 64'h22);

      // Flush of a full chain
      do_reset();
      fill7();
      chk("fl_full_occ", 64'(occupancy), 7);
      flush = 1;
      tick();
      flush = 0;
      chk("fl_valid", 64'(stage_valid), 64'h70);
      chk("fl_wren", 64'(stage_wren), 64'h70);
      chk("fl_s1", 64'(sc(1)), 0);
      chk("fl_s5", 64'(sc(5)), 64'h104);
      chk("fl_s6", 64'(sc(6)), 64'h103);
      chk("fl_s7", 64'(sc(7)), 64'h102);
      chk("fl_occ", 64'(occupancy), 3);

      // Stall with flush and issue pending, then flush acts on release
      stall = 1; flush = 1;
      drive(1'b1, 32'hDEAD, 1'b1, 3'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("st_valid%0d", i), 64'(stage_valid), 64'h70);
         chk($sformatf("st_s5_%0d", i), 64'(sc(5)), 64'h104);
         chk($sformatf("st_s7_%0d", i), 64'(sc(7)), 64'h102);
         chk($sformatf("st_occ%0d", i), 64'(occupancy), 3);
      end
      stall = 0;
      tick();
      idle();
      chk("st_rel_valid", 64'(stage_valid), 64'h60);
      chk("st_rel_s6", 64'(sc(6)), 64'h104);
      chk("st_rel_s7", 64'(sc(7)), 64'h103);
      chk("st_rel_occ", 64'(occupancy), 2);

      // Reset while stalled with a full chain
      do_reset();
      fill7();
      drive(1'b1, 32'h77, 1'b0, 3'd0);
      rd_en = 1; rd_addr = 5;
      #1;
      chk("rs_pre_hazard", 64'(hazard), 1);
      stall = 1; RST = 1;
      tick();
      chk("rs_valid", 64'(stage_valid), 0);
      chk("rs_ctrl_nonzero", 64'(|stage_ctrl), 0);
      chk("rs_occ", 64'(occupancy), 0);
      chk("rs_hazard", 64'(hazard), 0);
      RST = 0;
      idle();

      // Scoreboard: random stream observed at the last stage
      do_reset();
      for (int c = 0; c < 30; c++) begin
         if (c < 24) begin
            logic        v, w;
            logic [31:0] cw;
            logic [2:0]  a;
            v  = ($urandom_range(0, 3) != 0);
            cw = $urandom;
            w  = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            drive(v, cw, w, a);
            sb_q.push_back('{v, v ? cw : 32'h0, v & w, v ? a : 3'd0});
         end else begin
            idle();
         end
         tick();
         if (c >= 6) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
               exp_r = sb_q.pop_front();
               act_r = '{stage_valid[6], sc(7), stage_wren[6], stage_waddr[20:18]};
               chk($sformatf("sb_out%0d", c - 6), 64'(act_r), 64'(exp_r));
            end
         end
      end
      idle();

      // Reduced-depth instance
      tick();
      b_rst = 0;
      chk("sm_rst_occ", 64'(b_occupancy), 0);
      b_in_valid = 1; b_in_ctrl = 8'h5A; b_in_wren = 1; b_in_waddr = 3'd5;
      tick();
      b_in_ctrl = 8'h6B; b_in_wren = 0; b_in_waddr = 0;
      b_rd_en = 1; b_rd_addr = 3'd5;
      exp_small = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("sm_hazard_s%0d", i + 1), 64'(b_hazard), 64'(exp_small[i]));
         tick();
      end
      b_rd_en = 0;
      for (int j = 0; j < 4; j++) begin
         b_in_valid = 1; b_in_ctrl = 8'(j + 1); b_in_wren = 1; b_in_waddr = 3'(j);
         tick();
      end
      b_in_valid = 0; b_in_wren = 0;
      chk("sm_full_occ", 64'(b_occupancy), 4);
      b_flush = 1;
      tick();
      b_flush = 0;
      chk("sm_flush_valid", 64'(b_stage_valid), 0);
      chk("sm_flush_occ", 64'(b_occupancy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
